relu_drain_ctrl: RTL and testbench

- Sequences the ReLU activation stage at the output of the FFN systolic array.
- After a tile finishes, captures one row of N_COLS accumulator results in a single handshake, then drains them one column per beat.
- Each beat is requantised (arithmetic right shift plus signed saturation to DATA_WIDTH), passed through the existing relu module, and offered on a valid/ready stream to the activation buffer.
- Only one tile is in flight; a new tile needs a new start_i.

---
 rtl/ffn_pkg.sv | 16 +
 rtl/acc_requant.sv | 35 +++
 rtl/relu.sv | 14 +
 rtl/relu_drain_ctrl.sv | 108 ++++++++++
 tb/tb_relu_drain_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ffn_pkg.sv
// Shared types and default widths for the FFN output stage.
package ffn_pkg;

  localparam int unsigned N_COLS_DEF      = 4;
  localparam int unsigned ACC_WIDTH_DEF   = 24;
  localparam int unsigned DATA_WIDTH_DEF  = 8;
  localparam int unsigned SHIFT_WIDTH_DEF = 5;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACC,
    DRAIN,
    DONE
  } drain_state_e;

endpackage

// File: rtl/acc_requant.sv
// Requantise one accumulator: clamped arithmetic right shift, then signed saturation.
module acc_requant
  import ffn_pkg::*;
#(
  parameter int unsigned ACC_WIDTH   = ACC_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned SHIFT_WIDTH = SHIFT_WIDTH_DEF
) (
  input  logic signed [ACC_WIDTH-1:0]   acc,
  input  logic        [SHIFT_WIDTH-1:0] shift,
  output logic signed [DATA_WIDTH-1:0]  data
);

  localparam int unsigned MAX_SHIFT = ACC_WIDTH - 1;

  logic        [SHIFT_WIDTH-1:0]        shift_eff;
  logic signed [ACC_WIDTH-1:0]          shifted;
  logic        [ACC_WIDTH-DATA_WIDTH:0] upper;

  // Floor shift, then clamp to the signed output range using the bits above the output sign.
  always_comb begin
    shift_eff = shift;
    if (32'(shift) >= MAX_SHIFT) shift_eff = SHIFT_WIDTH'(MAX_SHIFT);
    shifted = acc >>> shift_eff;
    upper   = shifted[ACC_WIDTH-1:DATA_WIDTH-1];
    if (upper == '0 || upper == '1) begin
      data = shifted[DATA_WIDTH-1:0];
    end else if (shifted[ACC_WIDTH-1]) begin
      data = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      data = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/relu.sv
// Rectified linear unit on a signed value.
module relu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic signed [WIDTH-1:0] din,
  output logic        [WIDTH-1:0] dout
);

  // Negative inputs map to zero, everything else passes through.
  always_comb begin
    dout = din[WIDTH-1] ? '0 : din;
  end

endmodule

// File: rtl/relu_drain_ctrl.sv
// Captures one row of accumulators per tile and drains it column by column through requant + ReLU.
module relu_drain_ctrl
  import ffn_pkg::*;
#(
  parameter  int unsigned N_COLS      = N_COLS_DEF,
  parameter  int unsigned ACC_WIDTH   = ACC_WIDTH_DEF,
  parameter  int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter  int unsigned SHIFT_WIDTH = SHIFT_WIDTH_DEF,
  localparam int unsigned COL_WIDTH   = (N_COLS > 1) ? $clog2(N_COLS) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic [SHIFT_WIDTH-1:0]      shift_i,
  input  logic                        acc_valid_i,
  input  logic [N_COLS*ACC_WIDTH-1:0] acc_data_i,
  output logic                        acc_ready_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [DATA_WIDTH-1:0]       out_data_o,
  output logic [COL_WIDTH-1:0]        out_col_o,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam logic [COL_WIDTH-1:0] LAST_COL = COL_WIDTH'(N_COLS - 1);

  drain_state_e                 state_q, state_d;
  logic [COL_WIDTH-1:0]         col_q;
  logic [SHIFT_WIDTH-1:0]       shift_q;
  logic [ACC_WIDTH-1:0]         row_q [N_COLS];
  logic                         capture, beat, last_col;
  logic signed [DATA_WIDTH-1:0] requant;

  assign last_col  = (col_q == LAST_COL);
  assign out_col_o = col_q;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state and state-decoded handshake/status outputs.
  always_comb begin
    state_d     = state_q;
    acc_ready_o = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_d = WAIT_ACC;
      end
      WAIT_ACC: begin
        acc_ready_o = 1'b1;
        if (acc_valid_i) state_d = DRAIN;
      end
      DRAIN: begin
        out_valid_o = 1'b1;
        if (out_ready_i && last_col) state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    capture = acc_ready_o && acc_valid_i;
    beat    = out_valid_o && out_ready_i;
  end

  // Shift amount latched at start; row buffer loaded on capture; column advances per transferred beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      col_q   <= '0;
      for (int c = 0; c < N_COLS; c++) row_q[c] <= '0;
    end else begin
      if (state_q == IDLE && start_i) shift_q <= shift_i;
      if (capture) begin
        col_q <= '0;
        for (int c = 0; c < N_COLS; c++) row_q[c] <= acc_data_i[c*ACC_WIDTH +: ACC_WIDTH];
      end else if (beat && !last_col) begin
        col_q <= col_q + COL_WIDTH'(1);
      end
    end
  end

  acc_requant #(
    .ACC_WIDTH  (ACC_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .SHIFT_WIDTH(SHIFT_WIDTH)
  ) u_requant (
    .acc  (row_q[col_q]),
    .shift(shift_q),
    .data (requant)
  );

  relu #(
    .WIDTH(DATA_WIDTH)
  ) u_relu (
    .din (requant),
    .dout(out_data_o)
  );

endmodule

// File: tb/tb_relu_drain_ctrl.sv
// Self-checking bench for relu_drain_ctrl: vector table, scoreboard queue, and corner-case sequences.
module tb_relu_drain_ctrl;

  localparam int unsigned NC = 4;
  localparam int unsigned AW = 24;
  localparam int unsigned DW = 8;
  localparam int unsigned SW = 5;
  localparam int unsigned CW = 2;

  logic             clk_i, rst_ni, start_i, acc_valid_i, acc_ready_o;
  logic             out_valid_o, out_ready_i, busy_o, done_o;
  logic [SW-1:0]    shift_i;
  logic [NC*AW-1:0] acc_data_i;
  logic [DW-1:0]    out_data_o;
  logic [CW-1:0]    out_col_o;

  relu_drain_ctrl #(
    .N_COLS(NC), .ACC_WIDTH(AW), .DATA_WIDTH(DW), .SHIFT_WIDTH(SW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .shift_i(shift_i),
    .acc_valid_i(acc_valid_i), .acc_data_i(acc_data_i), .acc_ready_o(acc_ready_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_col_o(out_col_o), .busy_o(busy_o), .done_o(done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [SW-1:0]    shift;
    logic [NC*AW-1:0] row;
    logic [NC*DW-1:0] expv;
  } vec_t;

  typedef struct packed {
    logic [CW-1:0] col;
    logic [DW-1:0] data;
  } beat_t;

  beat_t         sb[$];
  int            checks, errors, beat_cnt, done_cnt;
  logic          stall_prev;
  logic [DW-1:0] held_data;
  logic [CW-1:0] held_col;
  vec_t          vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Independent reference: floor shift (clamped), then clip to 0..127.
  function automatic logic [DW-1:0] model(input logic [AW-1:0] acc, input logic [SW-1:0] sh);
    longint v;
    int     s;
    s = (int'(sh) > int'(AW) - 1) ? int'(AW) - 1 : int'(sh);
    v = longint'($signed(acc));
    v = v >>> s;
    if (v > 127) return 8'd127;
    if (v < 0) return 8'd0;
    return DW'(v);
  endfunction

  // One clock: sample at negedge (scoreboard, stall stability, done count), then return at posedge+1.
  task automatic cycle();
    @(negedge clk_i);
    if (out_valid_o && stall_prev) begin
      check("stall_data", 32'(out_data_o), 32'(held_data));
      check("stall_col", 32'(out_col_o), 32'(held_col));
    end
    if (out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got col %0d data %0d, expected no beat", out_col_o, out_data_o);
      end else begin
        beat_t e;
        e = sb.pop_front();
        check("beat_col", 32'(out_col_o), 32'(e.col));
        check("beat_data", 32'(out_data_o), 32'(e.data));
      end
      beat_cnt++;
    end
    if (done_o) done_cnt++;
    stall_prev = out_valid_o && !out_ready_i;
    held_data  = out_data_o;
    held_col   = out_col_o;
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_row(input logic [NC*DW-1:0] expv);
    for (int c = 0; c < NC; c++) sb.push_back({CW'(c), expv[c*DW +: DW]});
  endtask

  // Full tile: start, capture, drain (optionally with random backpressure), done.
  task automatic run_tile(input logic [SW-1:0] sh, input logic [NC*AW-1:0] row,
                          input logic [NC*DW-1:0] expv, input bit rnd_ready, input string tag);
    int b0, d0, cyc;
    b0 = beat_cnt;
    d0 = done_cnt;
    start_i = 1'b1;
    shift_i = sh;
    cycle();
    start_i = 1'b0;
    check({tag, "_acc_ready"}, 32'(acc_ready_o), 32'd1);
    acc_valid_i = 1'b1;
    acc_data_i  = row;
    push_row(expv);
    cycle();
    acc_valid_i = 1'b0;
    check({tag, "_valid_after_capture"}, 32'(out_valid_o), 32'd1);
    cyc = 0;
    while (beat_cnt - b0 < int'(NC) && cyc < 200) begin
      out_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle();
      cyc++;
    end
    out_ready_i = 1'b1;
    check({tag, "_beats"}, 32'(beat_cnt - b0), 32'(NC));
    if (!rnd_ready) check({tag, "_drain_cycles"}, 32'(cyc), 32'(NC));
    cycle();
    cycle();
    check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_busy_after"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    int b0, d0, cyc;
    logic [NC*AW-1:0] row;
    logic [NC*DW-1:0] expv;
    logic [SW-1:0]    sh;
    checks = 0; errors = 0; beat_cnt = 0; done_cnt = 0;
    stall_prev = 1'b0; held_data = '0; held_col = '0;
    start_i = 1'b0; shift_i = '0; acc_valid_i = 1'b0; acc_data_i = '0; out_ready_i = 1'b1;

    vecs[0] = '{shift: 5'd4,  row: {24'h000000, 24'hFFFF00, 24'h000050, 24'h000100},
                expv: {8'd0, 8'd0, 8'd5, 8'd16}};
    vecs[1] = '{shift: 5'd0,  row: {24'h000080, 24'h00007F, 24'hFFFC18, 24'h0003E8},
                expv: {8'd127, 8'd127, 8'd0, 8'd127}};
    vecs[2] = '{shift: 5'd23, row: {24'hFFFFFF, 24'h000001, 24'h800000, 24'h7FFFFF},
                expv: {8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[3] = '{shift: 5'd31, row: {24'hFFFFFF, 24'h400000, 24'h800000, 24'h7FFFFF},
                expv: {8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[4] = '{shift: 5'd8,  row: {24'h008000, 24'hFF8000, 24'h001280, 24'h7FFF00},
                expv: {8'd127, 8'd0, 8'd18, 8'd127}};
    vecs[5] = '{shift: 5'd1,  row: {24'hFFFFFF, 24'h000003, 24'h000101, 24'h0000FF},
                expv: {8'd0, 8'd1, 8'd127, 8'd127}};

    // Reset state.
    rst_ni = 1'b0;
    #12;
    check("rst_acc_ready", 32'(acc_ready_o), 32'd0);
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_out_col", 32'(out_col_o), 32'd0);
    check("rst_out_data", 32'(out_data_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    cycle();

    // Vector table, full-rate drain.
    for (int i = 0; i < 6; i++)
      run_tile(vecs[i].shift, vecs[i].row, vecs[i].expv, 1'b0, $sformatf("vec%0d", i));

    // Random backpressure on a known row and on random rows checked against the model.
    run_tile(vecs[0].shift, vecs[0].row, vecs[0].expv, 1'b1, "bp_vec0");
    for (int t = 0; t < 4; t++) begin
      sh = SW'($urandom_range(0, 31));
      for (int c = 0; c < NC; c++) begin
        row[c*AW +: AW]  = AW'($urandom);
        expv[c*DW +: DW] = model(row[c*AW +: AW], sh);
      end
      run_tile(sh, row, expv, 1'b1, $sformatf("rnd%0d", t));
    end

    // Handshake gating: acc_valid in IDLE ignored; start+acc_valid together captures a cycle later.
    acc_valid_i = 1'b1;
    acc_data_i  = vecs[0].row;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("idle_acc_ready", 32'(acc_ready_o), 32'd0);
      check("idle_out_valid", 32'(out_valid_o), 32'd0);
    end
    b0 = beat_cnt;
    d0 = done_cnt;
    start_i = 1'b1;
    shift_i = 5'd4;
    cycle();
    start_i = 1'b0;
    check("gate_wait_acc_ready", 32'(acc_ready_o), 32'd1);
    check("gate_no_early_capture", 32'(out_valid_o), 32'd0);
    push_row(vecs[0].expv);
    cycle();
    acc_valid_i = 1'b0;
    check("gate_capture_latency", 32'(out_valid_o), 32'd1);
    cycle();
    start_i     = 1'b1;
    acc_valid_i = 1'b1;
    acc_data_i  = vecs[1].row;
    cycle();
    start_i     = 1'b0;
    acc_valid_i = 1'b0;
    cyc = 0;
    while (beat_cnt - b0 < int'(NC) && cyc < 50) begin
      cycle();
      cyc++;
    end
    repeat (4) cycle();
    check("gate_beats", 32'(beat_cnt - b0), 32'(NC));
    check("gate_done", 32'(done_cnt - d0), 32'd1);
    check("gate_restart_ignored", 32'(busy_o), 32'd0);

    // Reset mid-drain after beat col1.
    b0 = beat_cnt;
    start_i = 1'b1;
    shift_i = 5'd4;
    cycle();
    start_i     = 1'b0;
    acc_valid_i = 1'b1;
    acc_data_i  = vecs[0].row;
    push_row(vecs[0].expv);
    cycle();
    acc_valid_i = 1'b0;
    cyc = 0;
    while (beat_cnt - b0 < 2 && cyc < 50) begin
      cycle();
      cyc++;
    end
    check("mid_beats_before_reset", 32'(beat_cnt - b0), 32'd2);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid_o), 32'd0);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_out_col", 32'(out_col_o), 32'd0);
    check("mid_rst_out_data", 32'(out_data_o), 32'd0);
    check("mid_rst_done", 32'(done_o), 32'd0);
    sb.delete();
    stall_prev = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni      = 1'b1;
    acc_valid_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("post_rst_no_valid", 32'(out_valid_o), 32'd0);
      check("post_rst_no_ready", 32'(acc_ready_o), 32'd0);
    end
    acc_valid_i = 1'b0;

    // Back-to-back tiles.
    b0 = beat_cnt;
    d0 = done_cnt;
    run_tile(vecs[4].shift, vecs[4].row, vecs[4].expv, 1'b0, "b2b_t1");
    run_tile(vecs[5].shift, vecs[5].row, vecs[5].expv, 1'b0, "b2b_t2");
    check("b2b_beats", 32'(beat_cnt - b0), 32'd8);
    check("b2b_done", 32'(done_cnt - d0), 32'd2);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
